riscv_mem_arbiter: RTL and testbench
====================================

// Module: riscv_mem_arbiter
// PURPOSE
//  Shares one single-ported req/gnt/rvalid memory between the riscv_core instruction and data
//  interfaces. Sits between the core and the memory model/SRAM. Routes in-order responses back
//  through an outstanding-ID FIFO. Allows the core to run on a unified-memory system.
// PARAMETERS
//  ADDR_WIDTH       32  address width, all three ports
//  MAX_OUTSTANDING  2   accepted-but-unanswered transfers (>=1); FIFO depth
// PORTS
//  clk_i           in   1   clock, rising edge
//  rst_ni          in   1   asynchronous active-low reset
//  instr_req_i     in   1   fetch request; held until instr_gnt_o
//  instr_addr_i    in   AW  fetch address
//  instr_gnt_o     out  1   fetch accepted this cycle
//  instr_rvalid_o  out  1   fetch response valid
//  instr_rdata_o   out  32  fetch response data
//  data_req_i      in   1   load/store request; held until data_gnt_o
//  data_addr_i     in   AW  load/store address
//  data_we_i       in   1   1=store
//  data_be_i       in   4   byte enables
//  data_wdata_i    in   32  store data
//  data_gnt_o      out  1   load/store accepted this cycle
//  data_rvalid_o   out  1   load/store response valid
//  data_rdata_o    out  32  load data
//  data_err_o      out  1   bus error, qualified by data_rvalid_o
//  mem_req_o       out  1   downstream request
//  mem_addr_o      out  AW  downstream address
//  mem_we_o        out  1   downstream write enable
//  mem_be_o        out  4   downstream byte enables
//  mem_wdata_o     out  32  downstream write data
//  mem_gnt_i       in   1   downstream accept
//  mem_rvalid_i    in   1   downstream response valid (in order)
//  mem_rdata_i     in   32  downstream response data
//  mem_err_i       in   1   downstream error, qualified by mem_rvalid_i
//  protocol_err_o  out  1   sticky: mem_rvalid_i seen with FIFO empty
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; sel_q=DATA; lock_q=0; protocol_err_o=0.
//  - Arbitration is combinational; grant is same-cycle: xxx_gnt_o = mem_gnt_i & mem_req_o & (sel==xxx).
//  - mem_req_o = (instr_req_i|data_req_i) & !full; mux drives mem_* from sel.
//    Instr selected: we=0, be=4'hF, wdata=0.
//  - Default priority is fixed: DATA over INSTR.
//  - Lock FSM, states OPEN/LOCKED:
//    - OPEN -> LOCKED when mem_req_o & !mem_gnt_i; sel frozen in sel_q.
//    - LOCKED -> OPEN on mem_gnt_i.
//    - In LOCKED the other requester cannot pre-empt; OBI address phase stays stable.
//  - FIFO (1-bit ID): push sel on mem_req_o&mem_gnt_i; pop on mem_rvalid_i.
//    - Push and pop in the same cycle are allowed.
//  - full = (count_q==MAX_OUTSTANDING). When full, mem_req_o=0 and no grants, even if a pop occurs
//    that cycle (no bypass).
//  - Response routing: head==DATA -> data_rvalid_o=mem_rvalid_i, data_err_o=mem_err_i.
//    head==INSTR -> instr_rvalid_o=mem_rvalid_i; mem_err_i dropped.
//    rdata is broadcast to both; only rvalid is steered. Zero-cycle response latency.
//  - mem_rvalid_i with FIFO empty: response dropped, protocol_err_o set until reset.
//  - Reset mid-transfer clears the FIFO. The memory must be reset together with this block;
//    stale responses set protocol_err_o.
// CONFIGURATION
//  MEM_ARB_RR_EN defined:
//    - Round-robin: last-granted register rr_q; when both request in OPEN, the non-last wins.
//    - rr_q updates on each grant; resets to INSTR (data wins first).
//  MEM_ARB_RR_EN undefined: fixed DATA>INSTR priority; rr_q not instantiated.
// STRUCTURE
//  Package riscv_mem_arb_pkg:
//    - typedef enum logic {REQ_INSTR=1'b0, REQ_DATA=1'b1} req_id_e
//    - typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_e
//  Sub-module riscv_mem_arb_id_fifo (DEPTH=MAX_OUTSTANDING, req_id_e entries, count/full/empty).
// TESTING
//  1. Instr only, addr 0x80, gnt same cycle, rvalid +1 with 0x13 -> instr_rvalid_o=1, rdata 0x13,
//     data_rvalid_o=0.
//  2. Both req, fixed priority -> data granted first, instr next cycle.
//     With MEM_ARB_RR_EN and back-to-back requests -> grants alternate D,I,D,I.
//  3. Instr req, mem_gnt_i low 3 cycles, data_req_i rises cycle 1 -> mem_addr_o stays instr addr
//     until gnt; data granted afterwards.
//  4. MAX_OUTSTANDING=2, two grants, no rvalid -> mem_req_o=0.
//     One rvalid -> next-cycle grant; responses return to I then D in order.
//  5. Store with mem_err_i=1 on rvalid -> data_err_o=1. Same on an instr response -> no error out.
//  6. rvalid with empty FIFO -> protocol_err_o=1 and held; rst_ni pulse clears it.

Source files
------------

// File: rtl/riscv_mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
package riscv_mem_arb_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   typedef enum logic {REQ_INSTR = 1'b0, REQ_DATA = 1'b1} req_id_e;
   typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_e;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Core-side and memory-side buses of the arbiter; slave = arbiter view, master = environment view.
interface riscv_mem_arbiter_if
   import riscv_mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  instr_req_i;
   logic [ADDR_WIDTH-1:0] instr_addr_i;
   logic                  instr_gnt_o;
   logic                  instr_rvalid_o;
   logic [DATA_W-1:0]     instr_rdata_o;

   logic                  data_req_i;
   logic [ADDR_WIDTH-1:0] data_addr_i;
   logic                  data_we_i;
   logic [BE_W-1:0]       data_be_i;
   logic [DATA_W-1:0]     data_wdata_i;
   logic                  data_gnt_o;
   logic                  data_rvalid_o;
   logic [DATA_W-1:0]     data_rdata_o;
   logic                  data_err_o;

   logic                  mem_req_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic                  mem_we_o;
   logic [BE_W-1:0]       mem_be_o;
   logic [DATA_W-1:0]     mem_wdata_o;
   logic                  mem_gnt_i;
   logic                  mem_rvalid_i;
   logic [DATA_W-1:0]     mem_rdata_i;
   logic                  mem_err_i;

   logic                  protocol_err_o;

   modport slave (
      input  instr_req_i, instr_addr_i,
      input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
      output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
      output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
      output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
      output protocol_err_o
   );

   modport master (
      output instr_req_i, instr_addr_i,
      output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
      input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
      input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
      input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
      input  protocol_err_o
   );

endinterface

// File: rtl/riscv_mem_arb_id_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unanswered memory transfers.
module riscv_mem_arb_id_fifo
   import riscv_mem_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  logic    push_i,
   input  req_id_e id_i,
   input  logic    pop_i,
   output req_id_e head_o,
   output logic    empty_o,
   output logic    full_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   req_id_e            mem_q [DEPTH];
   logic [PTR_W-1:0]   wptr_q, wptr_d;
   logic [PTR_W-1:0]   rptr_q, rptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               push_ok, pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign head_o  = mem_q[rptr_q];

   always_comb begin
      wptr_d = push_ok ? ptr_inc(wptr_q) : wptr_q;
      rptr_d = pop_ok  ? ptr_inc(rptr_q) : rptr_q;
      cnt_d  = cnt_q;
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wptr_q] <= id_i;
   end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one req/gnt/rvalid memory between instruction and data ports with in-order response routing.
// Optional build macro MEM_ARB_RR_EN: round-robin arbitration instead of fixed DATA>INSTR priority.
module riscv_mem_arbiter
   import riscv_mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   riscv_mem_arbiter_if.slave  bus
);

   arb_state_e            state_q, state_d;
   req_id_e               sel_q, sel_d, sel_c, prio_c, head;
   logic                  full, empty, mem_req_c, push, resp_valid;
   logic                  perr_q, perr_d;
   logic [ADDR_WIDTH-1:0] addr_c;

`ifdef MEM_ARB_RR_EN
   req_id_e               rr_q, rr_d;

   // Whoever was granted last yields when both request.
   assign prio_c = (rr_q == REQ_DATA) ? REQ_INSTR : REQ_DATA;
   assign rr_d   = push ? sel_c : rr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rr_q <= REQ_INSTR;
      else         rr_q <= rr_d;
   end
`else
   assign prio_c = REQ_DATA;
`endif

   assign mem_req_c = (bus.instr_req_i | bus.data_req_i) & ~full;
   assign push      = mem_req_c & bus.mem_gnt_i;

   // A stalled address phase keeps its owner until granted.
   always_comb begin
      sel_c = REQ_DATA;
      if (state_q == ARB_LOCKED)                   sel_c = sel_q;
      else if (bus.instr_req_i && bus.data_req_i)  sel_c = prio_c;
      else if (bus.instr_req_i)                    sel_c = REQ_INSTR;
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      case (state_q)
         ARB_OPEN: begin
            if (mem_req_c && !bus.mem_gnt_i) begin
               state_d = ARB_LOCKED;
               sel_d   = sel_c;
            end
         end
         ARB_LOCKED: begin
            if (bus.mem_gnt_i) state_d = ARB_OPEN;
         end
         default: state_d = ARB_OPEN;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ARB_OPEN;
         sel_q   <= REQ_DATA;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         perr_q  <= perr_d;
      end
   end

   riscv_mem_arb_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .id_i    (sel_c),
      .pop_i   (bus.mem_rvalid_i),
      .head_o  (head),
      .empty_o (empty),
      .full_o  (full)
   );

   // Responses with nothing outstanding are dropped and flagged until reset.
   assign perr_d     = perr_q | (bus.mem_rvalid_i & empty);
   assign resp_valid = bus.mem_rvalid_i & ~empty;

   assign addr_c = (sel_c == REQ_DATA) ? bus.data_addr_i : bus.instr_addr_i;

   assign bus.mem_req_o   = mem_req_c;
   assign bus.mem_addr_o  = addr_c;
   assign bus.mem_we_o    = (sel_c == REQ_DATA) & bus.data_we_i;
   assign bus.mem_be_o    = (sel_c == REQ_DATA) ? bus.data_be_i : {BE_W{1'b1}};
   assign bus.mem_wdata_o = (sel_c == REQ_DATA) ? bus.data_wdata_i : '0;

   assign bus.instr_gnt_o = push & (sel_c == REQ_INSTR);
   assign bus.data_gnt_o  = push & (sel_c == REQ_DATA);

   assign bus.instr_rvalid_o = resp_valid & (head == REQ_INSTR);
   assign bus.data_rvalid_o  = resp_valid & (head == REQ_DATA);
   assign bus.data_err_o     = resp_valid & (head == REQ_DATA) & bus.mem_err_i;
   assign bus.instr_rdata_o  = bus.mem_rdata_i;
   assign bus.data_rdata_o   = bus.mem_rdata_i;

   assign bus.protocol_err_o = perr_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed vector bench for riscv_mem_arbiter (default fixed-priority build).
module tb_riscv_mem_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_mis = 0;

   always #5 clk = ~clk;

   riscv_mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

   riscv_mem_arbiter #(
      .ADDR_WIDTH      (32),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      string       name;
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq;
      logic [31:0] daddr;
      logic        dwe;
      logic [3:0]  dbe;
      logic [31:0] dwd;
      logic        gnt;
      logic        rv;
      logic [31:0] rd;
      logic        err;
      logic        e_igt;
      logic        e_dgt;
      logic        e_mreq;
      logic [31:0] e_maddr;
      logic        e_mwe;
      logic [3:0]  e_mbe;
      logic [31:0] e_mwd;
      logic        e_irv;
      logic        e_drv;
      logic [31:0] e_rdata;
      logic        e_derr;
      logic        e_perr;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Inputs change just after the rising edge; combinational outputs are sampled on the falling edge.
   task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                        input logic [31:0] daddr, input logic dwe, input logic [3:0] dbe,
                        input logic [31:0] dwd, input logic gnt, input logic rv,
                        input logic [31:0] rd, input logic err);
      @(posedge clk);
      #1;
      bus.instr_req_i  = ireq;
      bus.instr_addr_i = iaddr;
      bus.data_req_i   = dreq;
      bus.data_addr_i  = daddr;
      bus.data_we_i    = dwe;
      bus.data_be_i    = dbe;
      bus.data_wdata_i = dwd;
      bus.mem_gnt_i    = gnt;
      bus.mem_rvalid_i = rv;
      bus.mem_rdata_i  = rd;
      bus.mem_err_i    = err;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_vec(input vec_t v);
      chk({v.name, ".ignt"},   32'(bus.instr_gnt_o),    32'(v.e_igt));
      chk({v.name, ".dgnt"},   32'(bus.data_gnt_o),     32'(v.e_dgt));
      chk({v.name, ".mreq"},   32'(bus.mem_req_o),      32'(v.e_mreq));
      chk({v.name, ".maddr"},  bus.mem_addr_o,          v.e_maddr);
      chk({v.name, ".mwe"},    32'(bus.mem_we_o),       32'(v.e_mwe));
      chk({v.name, ".mbe"},    32'(bus.mem_be_o),       32'(v.e_mbe));
      chk({v.name, ".mwdata"}, bus.mem_wdata_o,         v.e_mwd);
      chk({v.name, ".irv"},    32'(bus.instr_rvalid_o), 32'(v.e_irv));
      chk({v.name, ".drv"},    32'(bus.data_rvalid_o),  32'(v.e_drv));
      chk({v.name, ".irdata"}, bus.instr_rdata_o,       v.e_rdata);
      chk({v.name, ".drdata"}, bus.data_rdata_o,        v.e_rdata);
      chk({v.name, ".derr"},   32'(bus.data_err_o),     32'(v.e_derr));
      chk({v.name, ".perr"},   32'(bus.protocol_err_o), 32'(v.e_perr));
   endtask

   initial begin
      //         name      ireq iaddr    dreq daddr    we be     wdata         gnt rv rdata  err | igt dgt mreq maddr    mwe mbe    mwdata        irv drv rdata  derr perr
      tbl[0] = '{"idle0",  0,   0,       0,   0,       0, 4'h0, 0,            0,  0, 0,     0,    0,  0,  0,   0,       0,  4'h0, 0,            0,  0,  0,     0,   0};
      tbl[1] = '{"i_req",  1,   'h80,    0,   0,       0, 4'h0, 0,            1,  0, 0,     0,    1,  0,  1,   'h80,    0,  4'hF, 0,            0,  0,  0,     0,   0};
      tbl[2] = '{"i_rsp",  0,   0,       0,   0,       0, 4'h0, 0,            0,  1, 'h13,  0,    0,  0,  0,   0,       0,  4'h0, 0,            1,  0,  'h13,  0,   0};
      tbl[3] = '{"both_d", 1,   'h100,   1,   'h200,   0, 4'hF, 0,            1,  0, 0,     0,    0,  1,  1,   'h200,   0,  4'hF, 0,            0,  0,  0,     0,   0};
      tbl[4] = '{"both_i", 1,   'h100,   0,   'h200,   0, 4'hF, 0,            1,  1, 'hAA,  0,    1,  0,  1,   'h100,   0,  4'hF, 0,            0,  1,  'hAA,  0,   0};
      tbl[5] = '{"i_err",  0,   0,       0,   0,       0, 4'h0, 0,            0,  1, 'h55,  1,    0,  0,  0,   0,       0,  4'h0, 0,            1,  0,  'h55,  0,   0};
      tbl[6] = '{"st_req", 0,   0,       1,   'h300,   1, 4'h3, 'hDEADBEEF,   1,  0, 0,     0,    0,  1,  1,   'h300,   1,  4'h3, 'hDEADBEEF,   0,  0,  0,     0,   0};
      tbl[7] = '{"st_err", 0,   0,       0,   0,       0, 4'h0, 0,            0,  1, 0,     1,    0,  0,  0,   0,       0,  4'h0, 0,            0,  1,  0,     1,   0};
      tbl[8] = '{"idle1",  0,   0,       0,   0,       0, 4'h0, 0,            0,  0, 0,     0,    0,  0,  0,   0,       0,  4'h0, 0,            0,  0,  0,     0,   0};

      bus.instr_req_i  = 0; bus.instr_addr_i = 0;
      bus.data_req_i   = 0; bus.data_addr_i  = 0; bus.data_we_i = 0;
      bus.data_be_i    = 0; bus.data_wdata_i = 0;
      bus.mem_gnt_i    = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0; bus.mem_err_i = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].ireq, tbl[i].iaddr, tbl[i].dreq, tbl[i].daddr, tbl[i].dwe, tbl[i].dbe,
               tbl[i].dwd, tbl[i].gnt, tbl[i].rv, tbl[i].rd, tbl[i].err);
         check_vec(tbl[i]);
      end

      // Stalled instruction request keeps the bus while data arrives.
      drive(1, 'h400, 0, 'h500, 0, 4'hF, 0, 0, 0, 0, 0);
      chk("lock.c0.mreq", 32'(bus.mem_req_o), 1);
      chk("lock.c0.addr", bus.mem_addr_o, 'h400);
      chk("lock.c0.igt",  32'(bus.instr_gnt_o), 0);
      for (int c = 1; c < 3; c++) begin
         drive(1, 'h400, 1, 'h500, 0, 4'hF, 0, 0, 0, 0, 0);
         chk($sformatf("lock.c%0d.addr", c), bus.mem_addr_o, 'h400);
         chk($sformatf("lock.c%0d.be", c),   32'(bus.mem_be_o), 'hF);
         chk($sformatf("lock.c%0d.dgt", c),  32'(bus.data_gnt_o), 0);
      end
      drive(1, 'h400, 1, 'h500, 0, 4'hF, 0, 1, 0, 0, 0);
      chk("lock.c3.igt",  32'(bus.instr_gnt_o), 1);
      chk("lock.c3.dgt",  32'(bus.data_gnt_o), 0);
      chk("lock.c3.addr", bus.mem_addr_o, 'h400);
      drive(0, 0, 1, 'h500, 0, 4'hF, 0, 1, 0, 0, 0);
      chk("lock.c4.dgt",  32'(bus.data_gnt_o), 1);
      chk("lock.c4.addr", bus.mem_addr_o, 'h500);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h11, 0);
      chk("lock.r0.irv", 32'(bus.instr_rvalid_o), 1);
      chk("lock.r0.drv", 32'(bus.data_rvalid_o), 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h22, 0);
      chk("lock.r1.drv", 32'(bus.data_rvalid_o), 1);
      chk("lock.r1.irv", 32'(bus.instr_rvalid_o), 0);

      // Two outstanding fill the FIFO; a pop in the same cycle does not bypass.
      drive(1, 'h600, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("full.g0.igt", 32'(bus.instr_gnt_o), 1);
      drive(0, 0, 1, 'h700, 0, 4'hF, 0, 1, 0, 0, 0);
      chk("full.g1.dgt", 32'(bus.data_gnt_o), 1);
      drive(1, 'h800, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("full.c2.mreq", 32'(bus.mem_req_o), 0);
      chk("full.c2.igt",  32'(bus.instr_gnt_o), 0);
      drive(1, 'h800, 0, 0, 0, 0, 0, 1, 1, 'h33, 0);
      chk("full.c3.mreq", 32'(bus.mem_req_o), 0);
      chk("full.c3.igt",  32'(bus.instr_gnt_o), 0);
      chk("full.c3.irv",  32'(bus.instr_rvalid_o), 1);
      drive(1, 'h800, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("full.c4.igt",  32'(bus.instr_gnt_o), 1);
      chk("full.c4.addr", bus.mem_addr_o, 'h800);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h44, 0);
      chk("full.r1.drv", 32'(bus.data_rvalid_o), 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h55, 0);
      chk("full.r2.irv", 32'(bus.instr_rvalid_o), 1);
      chk("full.r2.perr", 32'(bus.protocol_err_o), 0);

      // Unexpected response: dropped, sticky error until reset.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h77, 1);
      chk("perr.c0.irv",  32'(bus.instr_rvalid_o), 0);
      chk("perr.c0.drv",  32'(bus.data_rvalid_o), 0);
      chk("perr.c0.derr", 32'(bus.data_err_o), 0);
      idle();
      chk("perr.c1", 32'(bus.protocol_err_o), 1);
      idle();
      chk("perr.c2", 32'(bus.protocol_err_o), 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk("perr.rst", 32'(bus.protocol_err_o), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle();
      chk("perr.after", 32'(bus.protocol_err_o), 0);
      chk("perr.mreq",  32'(bus.mem_req_o), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
